// File: rtl/bit_serializer_pkg.sv
// ============================================================================
// Module   : bit_serializer_pkg
// Brief    : Shared state encodings for the serializer and the 1011 detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // 1011 sequence detector states, named by the suffix matched so far
  localparam logic [2:0] c_DET_S0    = 3'd0;
  localparam logic [2:0] c_DET_S1    = 3'd1;
  localparam logic [2:0] c_DET_S10   = 3'd2;
  localparam logic [2:0] c_DET_S101  = 3'd3;
  localparam logic [2:0] c_DET_S1011 = 3'd4;

endpackage

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Brief    : Parallel-to-serial converter with one-word holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int             c_CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(WIDTH - 1);

  ser_state_e       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [c_CW-1:0]  r_cnt;

  ser_state_e       w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             w_hold_full_nxt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0] w_shift_adv;
  logic             w_head;
  logic             w_accept;
  logic             w_at_last;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_head      = r_shift[WIDTH-1];
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head      = r_shift[0];
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // clr blocks acceptance even though in_ready may still read 1
  assign w_accept  = in_valid & ~r_hold_full & ~clr;
  assign w_at_last = (r_state == SER_SHIFT) && (r_cnt == c_CNT_MAX);

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_cnt_nxt       = r_cnt;
    if (clr) begin
      w_state_nxt     = SER_IDLE;
      w_shift_nxt     = '0;
      w_hold_full_nxt = 1'b0;
      w_cnt_nxt       = '0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (w_accept) begin
            w_shift_nxt = in_data;
            w_cnt_nxt   = '0;
            w_state_nxt = SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (r_cnt == c_CNT_MAX) begin
            w_cnt_nxt = '0;
            if (r_hold_full) begin
              w_shift_nxt     = r_hold;
              w_hold_full_nxt = 1'b0;
            end else if (w_accept) begin
              w_shift_nxt = in_data;
            end else begin
              w_shift_nxt = '0;
              w_state_nxt = SER_IDLE;
            end
          end else begin
            w_shift_nxt = w_shift_adv;
            w_cnt_nxt   = r_cnt + c_CW'(1);
            if (w_accept) begin
              w_hold_nxt      = in_data;
              w_hold_full_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SER_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign in_ready  = ~r_hold_full;
  assign out_valid = (r_state == SER_SHIFT);
  assign out_bit   = out_valid & w_head;
  assign out_last  = w_at_last;
  assign busy      = (r_state == SER_SHIFT) | r_hold_full;

endmodule

`default_nettype wire
